lfsr_randgen: RTL and testbench
===============================

// Module: lfsr_randgen
// PURPOSE
//  Parametrised pseudo-random source for game logic. A free-running entropy counter is latched as the seed
//  on a rising edge of the user switch, or a seed is loaded directly. A Fibonacci LFSR then produces values
//  over a valid/ready stream, optionally bounded to [0, limit-1] by masked rejection sampling.
// PARAMETERS
//  WIDTH      12      counter, LFSR, seed and output width (>=4)
//  TAPS       12'h829 LFSR feedback mask; bit i set = lfsr[i] in XOR (default x^12+x^6+x^4+x+1, maximal)
//  MAX_TRIES  16      rejections allowed per output before fallback (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  enable     in   1      user switch; counter runs while low; rising edge = capture seed
//  seed_load  in   1      load seed_in as seed this cycle (priority over enable edge)
//  seed_in    in   WIDTH  external seed
//  limit      in   WIDTH  0 = unbounded; else outputs lie in [0, limit-1]; sampled only in RUN
//  out_ready  in   1      consumer accepts out_data
//  out_valid  out  1      out_data holds a new value
//  out_data   out  WIDTH  random value
//  seeded     out  1      sticky: a seed has been applied since reset
//  seed       out  WIDTH  last seed applied (after zero substitution)
// BEHAVIOUR
//  Reset: counter=0, lfsr=1, enable_q=0, state=UNSEEDED, out_valid=0, out_data=0, seeded=0, seed=0.
//  Counter: +1 on every edge with enable=0, holds while enable=1; wraps 2^WIDTH-1 -> 0.
//  Seed event: seed_load=1, or enable & ~enable_q. s = seed_load ? seed_in : counter; s==0 -> s=1 (no lock-up).
//   Next edge: lfsr<=s, seed<=s, seeded<=1, out_valid<=0, tries<=0, state<=RUN. Any state, including HOLD
//   (pending value discarded). Same-cycle seed event + handshake: transfer counts done, seed wins.
//  LFSR step: nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
//  mask = smallest 2^k-1 >= limit-1 (limit=1 -> 0); cand = nxt & mask (limit=0 -> cand = nxt).
//  States:
//   UNSEEDED: lfsr frozen, out_valid=0, out_ready ignored; leave only on seed event.
//   RUN: each edge lfsr<=nxt.
//    - limit==0 or cand<limit: out_data<=cand, out_valid<=1, tries<=0 -> HOLD.
//    - else if tries==MAX_TRIES-1: out_data<=cand-limit (always < limit), out_valid<=1, tries<=0 -> HOLD.
//    - else tries<=tries+1, stay RUN.
//   HOLD: out_valid=1, out_data and lfsr stable; limit changes ignored.
//    out_valid & out_ready at edge -> out_valid<=0, state<=RUN.
//  Latency: seed event sampled at edge E -> RUN after E -> out_valid=1 after E+1 if first candidate accepted.
//  Throughput: at most one value per 2 cycles (out_valid low for one cycle after each transfer).
//  Reset mid-operation returns every register to its reset value on that edge; seed history is lost.
//  Unbounded period: 2^WIDTH-1 with a maximal TAPS.
// TESTING
//  1 reset=1 for 2 edges with random inputs -> out_valid=0, out_data=0, seeded=0, seed=0.
//  2 seed_load=1, seed_in=12'h001, limit=0, out_ready=1 -> seed=001, seeded=1; out_data 003,007,00F
//    on successive valid cycles; out_valid toggles 1,0,1,0.
//  3 seed_load with seed_in=0 -> seed=12'h001, same stream as test 2; enable low 100 edges after reset,
//    then high -> seed=12'h064.
//  4 limit=5, 4096 handshakes -> every out_data<5, all of 0..4 appear; limit=1 -> always 0.
//  5 out_ready=0 for 10 edges in HOLD -> out_valid=1, out_data constant; seed_load in HOLD -> out_valid=0
//    next edge, new stream starts from new seed.
//  6 limit=0, seed 001 -> 4095 outputs with no repeats and no zero; output 4096 = output 1 (003).

Source files
------------

// File: rtl/lfsr_randgen.sv
// lfsr_randgen: seeded Fibonacci LFSR random source with valid/ready output and bounded rejection sampling
module lfsr_randgen #(
   parameter int                WIDTH     = 12,
   parameter logic [WIDTH-1:0]  TAPS      = 12'h829,
   parameter int                MAX_TRIES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [WIDTH-1:0] limit,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             seeded,
   output logic [WIDTH-1:0] seed
);
   localparam int TW = $clog2(MAX_TRIES + 1);
   typedef enum logic [1:0] {UNSEEDED, RUN, HOLD} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_cnt, r_lfsr;
   logic             r_en_q;
   logic [TW-1:0]    r_tries;
   logic             w_seed_evt, w_accept, w_last_try;
   logic [WIDTH-1:0] w_seed_raw, w_seed, w_nxt, w_lm1, w_mask, w_cand;
   assign w_seed_evt = seed_load | (enable & ~r_en_q);
   assign w_seed_raw = seed_load ? seed_in : r_cnt;
   // an all-zero seed would lock the LFSR, so substitute 1
   assign w_seed     = (w_seed_raw == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_seed_raw;
   assign w_nxt      = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
   assign w_lm1      = limit - 1'b1;
   always_comb begin
      w_mask = w_lm1;
      for (int i = 1; i < WIDTH; i++) w_mask = w_mask | (w_lm1 >> i);
   end
   assign w_cand     = (limit == '0) ? w_nxt : (w_nxt & w_mask);
   assign w_accept   = (limit == '0) | (w_cand < limit);
   assign w_last_try = (r_tries == TW'(MAX_TRIES - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_lfsr    <= {{(WIDTH-1){1'b0}}, 1'b1};
         r_en_q    <= 1'b0;
         r_tries   <= '0;
         r_state   <= UNSEEDED;
         out_valid <= 1'b0;
         out_data  <= '0;
         seeded    <= 1'b0;
         seed      <= '0;
      end else begin
         r_en_q <= enable;
         if (!enable) r_cnt <= r_cnt + 1'b1;
         if (w_seed_evt) begin
            r_lfsr    <= w_seed;
            seed      <= w_seed;
            seeded    <= 1'b1;
            out_valid <= 1'b0;
            r_tries   <= '0;
            r_state   <= RUN;
         end else begin
            case (r_state)
               RUN: begin
                  r_lfsr <= w_nxt;
                  if (w_accept || w_last_try) begin
                     // fallback cand-limit stays below limit because mask < 2*limit
                     out_data  <= w_accept ? w_cand : w_cand - limit;
                     out_valid <= 1'b1;
                     r_tries   <= '0;
                     r_state   <= HOLD;
                  end else begin
                     r_tries <= r_tries + 1'b1;
                  end
               end
               HOLD: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     r_state   <= RUN;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_lfsr_randgen.sv
// tb_lfsr_randgen: directed self-checking bench for lfsr_randgen
module tb_lfsr_randgen;
   logic        clk = 1'b0;
   logic        reset, enable, seed_load, out_ready, out_valid, seeded;
   logic [11:0] seed_in, limit, out_data, seed;
   int          n_chk = 0, n_fail = 0;
   bit          seen [4096];
   always #5 clk = ~clk;
   lfsr_randgen dut (
      .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
      .limit(limit), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .seeded(seeded), .seed(seed)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic get_val(output logic [11:0] v);
      int n = 0;
      while (!out_valid && n < 100) begin
         tick;
         n++;
      end
      if (!out_valid) check("valid_timeout", {31'b0, out_valid}, 1);
      v = out_data;
      tick;
   endtask
   task automatic reseed(input logic [11:0] s, input logic [11:0] lim);
      seed_load = 1'b1;
      seed_in   = s;
      limit     = lim;
      tick;
      seed_load = 1'b0;
   endtask
   initial begin
      logic [11:0] v, first, last;
      logic [4:0]  cov;
      int          zeros, dups;
      reset = 1'b1; enable = 1'($urandom); seed_load = 1'($urandom); seed_in = 12'($urandom);
      limit = 12'($urandom); out_ready = 1'($urandom);
      tick;
      enable = 1'($urandom); seed_load = 1'($urandom); seed_in = 12'($urandom);
      tick;
      check("rst_valid", {31'b0, out_valid}, 0);
      check("rst_data", {20'b0, out_data}, 0);
      check("rst_seeded", {31'b0, seeded}, 0);
      check("rst_seed", {20'b0, seed}, 0);
      reset = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_in = '0; limit = '0; out_ready = 1'b1;
      repeat (100) tick;
      check("unseeded_valid", {31'b0, out_valid}, 0);
      check("unseeded_flag", {31'b0, seeded}, 0);
      enable = 1'b1;
      tick;
      check("cnt_seed", {20'b0, seed}, 12'h064);
      check("cnt_seeded", {31'b0, seeded}, 1);
      check("cnt_lat_valid0", {31'b0, out_valid}, 0);
      tick;
      check("cnt_lat_valid1", {31'b0, out_valid}, 1);
      check("cnt_first", {20'b0, out_data}, 12'h0C9);
      reseed(12'h001, 12'h000);
      check("s1_seed", {20'b0, seed}, 12'h001);
      check("s1_valid0", {31'b0, out_valid}, 0);
      tick; check("s1_v1", {31'b0, out_valid}, 1); check("s1_d1", {20'b0, out_data}, 12'h003);
      tick; check("s1_v2", {31'b0, out_valid}, 0);
      tick; check("s1_v3", {31'b0, out_valid}, 1); check("s1_d2", {20'b0, out_data}, 12'h007);
      tick; check("s1_v4", {31'b0, out_valid}, 0);
      tick; check("s1_v5", {31'b0, out_valid}, 1); check("s1_d3", {20'b0, out_data}, 12'h00F);
      reseed(12'h000, 12'h000);
      check("zero_seed", {20'b0, seed}, 12'h001);
      get_val(v); check("zero_d1", {20'b0, v}, 12'h003);
      get_val(v); check("zero_d2", {20'b0, v}, 12'h007);
      reseed(12'h001, 12'h000);
      out_ready = 1'b0;
      tick;
      limit = 12'h003;
      repeat (10) tick;
      check("hold_valid", {31'b0, out_valid}, 1);
      check("hold_data", {20'b0, out_data}, 12'h003);
      reseed(12'h0A5, 12'h000);
      check("hold_seed_valid", {31'b0, out_valid}, 0);
      check("hold_seed", {20'b0, seed}, 12'h0A5);
      tick;
      check("hold_new_valid", {31'b0, out_valid}, 1);
      check("hold_new_data", {20'b0, out_data}, 12'h14A);
      out_ready = 1'b1;
      reseed(12'h001, 12'h005);
      cov = '0;
      for (int i = 0; i < 4096; i++) begin
         get_val(v);
         check("lim5_range", {31'b0, v < 12'd5}, 1);
         if (v < 12'd5) cov[v[2:0]] = 1'b1;
      end
      check("lim5_cover", {27'b0, cov}, 5'h1F);
      reseed(12'h123, 12'h001);
      for (int i = 0; i < 20; i++) begin
         get_val(v);
         check("lim1_zero", {20'b0, v}, 0);
      end
      reseed(12'h001, 12'h000);
      zeros = 0; dups = 0; first = '0; last = '0;
      for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
      for (int i = 1; i <= 4096; i++) begin
         get_val(v);
         if (i == 1) first = v;
         if (i <= 4095) begin
            if (v == '0) zeros++;
            if (seen[v]) dups++;
            seen[v] = 1'b1;
         end else last = v;
      end
      check("per_zeros", zeros, 0);
      check("per_dups", dups, 0);
      check("per_first", {20'b0, first}, 12'h003);
      check("per_wrap", {20'b0, last}, 12'h003);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midrst_seeded", {31'b0, seeded}, 0);
      check("midrst_seed", {20'b0, seed}, 0);
      check("midrst_valid", {31'b0, out_valid}, 0);
      check("midrst_data", {20'b0, out_data}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
